mp_pingpong_scheduler: RTL and testbench
========================================

MP_PINGPONG_SCHEDULER -- requirements
Module: mp_pingpong_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the word width of din/dout.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the words per bank (address width = log2(DEPTH)).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse that starts a frame.
REQ-006 SHALL have port ifm_width  input  9  input feature-map width, sampled on frame_start.
REQ-007 SHALL have port burst_total  input  8  number of bursts in the frame, sampled on frame_start.
REQ-008 SHALL have port din_valid / din / din_ready  input / input DATA_W / output 1  upstream valid-ready write channel.
REQ-009 SHALL have port dout_valid / dout / dout_ready  output 1 / output DATA_W / input 1  downstream valid-ready read channel.
REQ-010 SHALL have port dout_last  output  1  marks the final word of each burst, qualified by dout_valid.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL latch burst_len on frame_start in IDLE: 6 when ifm_width==26, 13 otherwise.
REQ-014 SHALL latch burst_total together with burst_len; frame_start outside IDLE SHALL be ignored.
REQ-015 SHALL implement the FSM IDLE -> RUN on frame_start, RUN -> DONE when the read-burst count equals burst_total and the output skid is empty, and DONE -> IDLE unconditionally after 1 cycle.
REQ-016 SHALL take RUN -> DONE on the next cycle when burst_total==0, with no din_ready ever asserted.
REQ-017 SHALL drive frame_done high for exactly the single cycle spent in DONE.
REQ-018 SHALL hold two banks (0/1) with full flags full[1:0], a write pointer wr_bank/wr_ptr, and a read pointer rd_bank/rd_ptr.
REQ-019 SHALL assert din_ready = RUN & !full[wr_bank] & (write-burst count < burst_total).
REQ-020 SHALL, on a write handshake, write din to wr_bank[wr_ptr] and increment wr_ptr.
REQ-021 SHALL, on the handshake where wr_ptr==burst_len-1: set full[wr_bank], clear wr_ptr to 0, toggle wr_bank, and increment the write-burst count.
REQ-022 SHALL issue a bank read when full[rd_bank] and the skid has a free slot after the current cycle's pop; read data SHALL be registered into the skid 1 cycle later.
REQ-023 SHALL, on issuing the read at rd_ptr==burst_len-1: clear full[rd_bank], clear rd_ptr, toggle rd_bank, increment the read-burst count, and tag that word dout_last.
REQ-024 SHALL use a 2-entry output skid: dout_valid when non-empty; pop on dout_valid&dout_ready; dout/dout_last held stable while dout_ready is low.
REQ-025 SHALL sustain 1 word/cycle at both ports with dout_ready tied high; first dout_valid 2 cycles after the full flag sets.
REQ-026 SHALL handle a write set and a read clear of full in the same cycle on opposite banks; same-bank collision is structurally impossible (writer needs !full, reader needs full).
REQ-027 SHALL allow a bank to refill as soon as its final read is issued, even while its words remain in the skid.
REQ-028 SHALL keep count widths at 8 bits for bursts and log2(DEPTH) bits for pointers, with no wrap within a frame (burst_len ≤ DEPTH).

Reset
REQ-029 SHALL, while rst is high at a clock edge: go to IDLE, clear full to 0, set wr/rd bank and pointers to 0, clear burst counts, and empty the skid.
REQ-030 SHALL hold outputs din_ready, dout_valid, dout_last, frame_done and busy at 0 while in reset; dout SHALL be 0.
REQ-031 SHALL abort a frame on rst mid-frame without emitting frame_done; bank contents are not cleared.

Structure
REQ-032 SHALL place in package mp_pkg: the FSM state enum (IDLE, RUN, DONE), the constants BURST_LEN_26=6 and BURST_LEN_DEF=13, and WIDTH_26=26.
REQ-033 SHALL instantiate the sub-module mp_pp_bank (DEPTH x DATA_W, single port, 1-cycle read latency) twice.

Verification
REQ-034 SHALL cover: ifm_width=26, burst_total=4, continuous valid/ready -> 24 words out in order, dout_last on words 6/12/18/24, frame_done once.
REQ-035 SHALL cover: ifm_width=52, burst_total=3 -> 39 words, dout_last every 13th word.
REQ-036 SHALL cover: dout_ready low for 40 cycles after start, width 26 -> din_ready drops after 12 words (both banks full), no data lost or reordered.
REQ-037 SHALL cover: random 50% din_valid/dout_ready, burst_total=10 -> scoreboard match and frame_done exactly once.
REQ-038 SHALL cover: burst_total=0 -> frame_done 2 cycles after frame_start, din_ready never high.
REQ-039 SHALL cover: rst asserted after 9 words, then a new frame -> frame_done not emitted for the aborted frame; the new frame's output is correct from word 1.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared types and constants for the ping-pong burst scheduler.
package mp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BURST_LEN_26  = 6;
    localparam int BURST_LEN_DEF = 13;
    localparam int WIDTH_26      = 26;

endpackage

// File: rtl/mp_pp_bank.sv
// Single-port DEPTH x DATA_W buffer bank with a registered (1-cycle) read.
module mp_pp_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mp_pingpong_scheduler.sv
// Two-bank ping-pong burst buffer: upstream fills one bank while the other
// drains through a 2-entry output skid, one burst per bank at a time.
module mp_pingpong_scheduler
    import mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [8:0]        ifm_width,
    input  logic [7:0]        burst_total,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              frame_done,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [AW-1:0]     len_m1_q, len_m1_d;
    logic [7:0]        total_q, total_d;
    logic [7:0]        wr_burst_q, wr_burst_d, rd_burst_q, rd_burst_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              pend_q, pend_d, pend_bank_q, pend_bank_d, pend_last_q, pend_last_d;
    logic [DATA_W-1:0] skid_data_q [2];
    logic [DATA_W-1:0] skid_data_d [2];
    logic [1:0]        skid_last_q, skid_last_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic [DATA_W-1:0] bank_rdata [2];

    logic       in_run, wr_hs, wr_last, rd_issue, rd_last, pop;
    logic [2:0] occ_after;

    assign in_run     = (state_q == RUN);
    assign din_ready  = !rst && in_run && !full_q[wr_bank_q] && (wr_burst_q < total_q);
    assign dout_valid = !rst && (skid_cnt_q != 2'd0);
    assign dout       = rst ? '0 : skid_data_q[0];
    assign dout_last  = dout_valid && skid_last_q[0];
    assign frame_done = !rst && (state_q == DONE);
    assign busy       = !rst && (state_q != IDLE);

    assign wr_hs    = din_valid && din_ready;
    assign wr_last  = wr_hs && (wr_ptr_q == len_m1_q);
    assign pop      = dout_valid && dout_ready;
    // Occupancy counts the read already in flight so the skid never overflows.
    assign occ_after = {1'b0, skid_cnt_q} + {2'b0, pend_q} - {2'b0, pop};
    assign rd_issue = !rst && in_run && full_q[rd_bank_q] && (occ_after < 3'd2);
    assign rd_last  = rd_issue && (rd_ptr_q == len_m1_q);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic we, re;
            assign we = wr_hs && (wr_bank_q == 1'(gi));
            assign re = rd_issue && (rd_bank_q == 1'(gi));
            mp_pp_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank (
                .clk     (clk),
                .we_i    (we),
                .re_i    (re),
                .addr_i  (we ? wr_ptr_q : rd_ptr_q),
                .wdata_i (din),
                .rdata_o (bank_rdata[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        len_m1_d    = len_m1_q;
        total_d     = total_q;
        wr_burst_d  = wr_burst_q;
        rd_burst_d  = rd_burst_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pend_d      = rd_issue;
        pend_bank_d = rd_bank_q;
        pend_last_d = rd_last;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_cnt_d  = skid_cnt_q;

        case (state_q)
            IDLE: if (frame_start) begin
                state_d    = RUN;
                len_m1_d   = (ifm_width == 9'(WIDTH_26)) ? AW'(BURST_LEN_26 - 1)
                                                         : AW'(BURST_LEN_DEF - 1);
                total_d    = burst_total;
                wr_burst_d = '0;
                rd_burst_d = '0;
                full_d     = '0;
                wr_bank_d  = 1'b0;
                rd_bank_d  = 1'b0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
            end
            RUN: if (rd_burst_q == total_q && skid_cnt_q == 2'd0 && !pend_q) begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (wr_hs) begin
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_ptr_d          = '0;
                wr_bank_d         = !wr_bank_q;
                wr_burst_d        = wr_burst_q + 8'd1;
            end else begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end

        // The bank is released at its final read issue, before the word leaves the skid.
        if (rd_issue) begin
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_ptr_d          = '0;
                rd_bank_d         = !rd_bank_q;
                rd_burst_d        = rd_burst_q + 8'd1;
            end else begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
        end

        case ({pend_q, pop})
            2'b10: begin
                if (skid_cnt_q == 2'd0) begin
                    skid_data_d[0] = bank_rdata[pend_bank_q];
                    skid_last_d[0] = pend_last_q;
                end else begin
                    skid_data_d[1] = bank_rdata[pend_bank_q];
                    skid_last_d[1] = pend_last_q;
                end
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid_data_d[0] = skid_data_q[1];
                skid_last_d[0] = skid_last_q[1];
                skid_cnt_d     = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_data_d[0] = bank_rdata[pend_bank_q];
                    skid_last_d[0] = pend_last_q;
                end else begin
                    skid_data_d[0] = skid_data_q[1];
                    skid_last_d[0] = skid_last_q[1];
                    skid_data_d[1] = bank_rdata[pend_bank_q];
                    skid_last_d[1] = pend_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            len_m1_q       <= '0;
            total_q        <= '0;
            wr_burst_q     <= '0;
            rd_burst_q     <= '0;
            full_q         <= '0;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pend_q         <= 1'b0;
            pend_bank_q    <= 1'b0;
            pend_last_q    <= 1'b0;
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_last_q    <= '0;
            skid_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            len_m1_q       <= len_m1_d;
            total_q        <= total_d;
            wr_burst_q     <= wr_burst_d;
            rd_burst_q     <= rd_burst_d;
            full_q         <= full_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pend_q         <= pend_d;
            pend_bank_q    <= pend_bank_d;
            pend_last_q    <= pend_last_d;
            skid_data_q[0] <= skid_data_d[0];
            skid_data_q[1] <= skid_data_d[1];
            skid_last_q    <= skid_last_d;
            skid_cnt_q     <= skid_cnt_d;
        end
    end

endmodule

// File: tb/tb_mp_pingpong_scheduler.sv
// Scoreboard bench: accepted input words queue their expected output, a monitor pops and compares.
module tb_mp_pingpong_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [8:0]  ifm_width;
    logic [7:0]  burst_total;
    logic        din_valid;
    logic [31:0] din;
    logic        din_ready;
    logic        dout_valid;
    logic [31:0] dout;
    logic        dout_ready;
    logic        dout_last;
    logic        frame_done;
    logic        busy;

    always #5 clk = ~clk;

    mp_pingpong_scheduler #(.DATA_W(32), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .ifm_width   (ifm_width),
        .burst_total (burst_total),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (din_ready),
        .dout_valid  (dout_valid),
        .dout        (dout),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    logic [32:0] exp_q[$];
    int wr_cnt, rd_cnt, done_cnt, cur_len, exp_words, start_cyc;
    int w_last0_cyc, first_valid_cyc, first_out_cyc, last_out_cyc, done_cyc;
    bit din_ready_seen;
    logic [7:0] tag;

    always @(posedge clk) cyc++;

    // Monitor: records accepted inputs into the scoreboard and checks every output word.
    always @(negedge clk) begin
        logic [32:0] e;
        if (din_valid && din_ready) begin
            exp_q.push_back({((wr_cnt % cur_len) == cur_len - 1), din});
            if (wr_cnt == cur_len - 1) w_last0_cyc = cyc;
            wr_cnt++;
        end
        if (din_ready) din_ready_seen = 1'b1;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (dout_valid && dout_ready) begin
            if (rd_cnt == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_word%0d: got last=%0b data=%08h, required none (queue empty)",
                         rd_cnt, dout_last, dout);
            end else begin
                e = exp_q.pop_front();
                if ({dout_last, dout} !== e) begin
                    n_fail++;
                    $display("FAIL out_word%0d: got last=%0b data=%08h, required last=%0b data=%08h",
                             rd_cnt, dout_last, dout, e[32], e[31:0]);
                end
            end
            rd_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic step(input int vpct, input int rpct);
        din_valid  = (wr_cnt < exp_words) && ($urandom_range(99) < vpct);
        din        = {tag, 24'(wr_cnt)};
        dout_ready = ($urandom_range(99) < rpct);
        @(posedge clk) #1;
    endtask

    task automatic start_frame(input int width, input int total, input logic [7:0] t);
        @(posedge clk) #1;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
        cur_len = (width == 26) ? 6 : 13;
        exp_words = total * cur_len;
        first_valid_cyc = -1; first_out_cyc = -1; w_last0_cyc = -1; done_cyc = -1;
        din_ready_seen = 1'b0;
        tag = t;
        start_cyc = cyc;
        frame_start = 1'b1;
        ifm_width = 9'(width);
        burst_total = 8'(total);
        din_valid = 1'b0;
        @(posedge clk) #1;
        frame_start = 1'b0;
    endtask

    // fs_at: step index at which a stray frame_start (width 26, total 1) is driven mid-frame.
    task automatic run_until_done(input string name, input int vpct, input int rpct, input int fs_at);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            if (k == fs_at) begin
                frame_start = 1'b1; ifm_width = 9'd26; burst_total = 8'd1;
            end else begin
                frame_start = 1'b0;
            end
            step(vpct, rpct);
            k++;
        end
        frame_start = 1'b0;
        if (done_cnt == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no frame_done, required frame_done within 3000 cycles", name);
        end
        for (int i = 0; i < 5; i++) step(0, 100);
        check({name, "_frame_done_count"}, 64'(done_cnt), 64'd1);
        check({name, "_words_out"}, 64'(rd_cnt), 64'(exp_words));
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; ifm_width = '0; burst_total = '0;
        din_valid = 1'b0; din = '0; dout_ready = 1'b0;
        cur_len = 6; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_words = 0; tag = '0;
        first_valid_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", 64'(din_ready), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout_last", 64'(dout_last), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        rst = 1'b0;

        // Width 26, 4 bursts, continuous flow.
        start_frame(26, 4, 8'hA1);
        check("f1_busy_in_run", 64'(busy), 64'd1);
        run_until_done("f1", 100, 100, -1);
        check("f1_first_valid_latency", 64'(first_valid_cyc - w_last0_cyc), 64'd3);
        check("f1_sustained_span", 64'(last_out_cyc - first_out_cyc), 64'd23);

        // Width 52, 3 bursts of 13; a stray frame_start mid-frame must be ignored.
        start_frame(52, 3, 8'hB2);
        run_until_done("f2", 100, 100, 10);

        // Downstream stalled for 40 cycles: both banks fill after 12 words.
        start_frame(26, 4, 8'hC3);
        for (int k = 0; k < 40; k++) begin
            if (k == 35) begin
                check("f3_words_in_stalled", 64'(wr_cnt), 64'd12);
                check("f3_din_ready_stalled", 64'(din_ready), 64'd0);
                check("f3_dout_valid_stalled", 64'(dout_valid), 64'd1);
            end
            step(100, 0);
        end
        run_until_done("f3", 100, 100, -1);

        // Random 50% traffic on both sides, 10 bursts.
        start_frame(52, 10, 8'hD4);
        run_until_done("f4", 50, 50, -1);

        // Empty frame.
        start_frame(26, 0, 8'hE5);
        run_until_done("f5", 100, 100, -1);
        check("f5_done_delay", 64'(done_cyc - start_cyc), 64'd2);
        check("f5_din_ready_seen", 64'(din_ready_seen), 64'd0);

        // Abort after 9 words, then a fresh frame.
        start_frame(26, 4, 8'hF6);
        for (int k = 0; k < 50 && wr_cnt < 9; k++) step(100, 100);
        check("f6_words_before_abort", 64'(wr_cnt), 64'd9);
        din_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk) #1;
        check("f6_busy_in_rst", 64'(busy), 64'd0);
        check("f6_dout_valid_in_rst", 64'(dout_valid), 64'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 100);
        check("f6_no_done_for_abort", 64'(done_cnt), 64'd0);
        start_frame(26, 2, 8'h17);
        run_until_done("f7", 100, 100, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
